// File: rtl/uart_tx_param.sv
// UART transmitter with configurable data width, parity and stop bits, fed from
// a small transmit FIFO so queued words go out as contiguous frames.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | line high, waiting for a queued word
// S_START | start bit (line low)
// S_DATA  | data bits, LSB first
// S_PARITY| parity bit (only when PARITY != 0)
// S_STOP  | STOP_BITS stop bits, may chain straight into S_START
module uart_tx_param #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   input  logic [DATA_BITS-1:0]          tx_data,
   output logic                          tx,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int CPB   = CLK_FREQ / BAUD_RATE;
   localparam int BW    = $clog2(CPB);
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int CW    = PW + 1;
   localparam int BIT_W = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               state_q, state_d;
   logic [BW-1:0]        baud_q, baud_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
   logic [PW-1:0]        wr_q, wr_d;
   logic [PW-1:0]        rd_q, rd_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;
   logic                 bit_end;
   logic [DATA_BITS-1:0] head;
   logic                 head_par;

   assign full     = (cnt_q == CW'(FIFO_DEPTH));
   assign empty    = (cnt_q == '0);
   assign push     = tx_valid && !full;
   assign head     = mem_q[rd_q];
   // Odd mode inverts the data XOR so data plus parity carries an odd number of ones.
   assign head_par = (PARITY == 1) ? ~(^head) : (^head);
   assign bit_end  = (baud_q == BW'(CPB - 1));

   assign tx_ready   = !full;
   assign tx         = tx_q;
   assign tx_busy    = (state_q != S_IDLE);
   assign fifo_count = cnt_q;

   always_comb begin : fifo_comb
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push) begin
         mem_d[wr_q] = tx_data;
         wr_d        = wr_q + PW'(1);
      end
      if (pop) begin
         rd_d = rd_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin : fsm_comb
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;
      pop     = 1'b0;

      if (state_q != S_IDLE) begin
         baud_d = bit_end ? '0 : baud_q + BW'(1);
      end

      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            tx_d   = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               state_d = S_START;
               tx_d    = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               bit_d   = '0;
               tx_d    = shift_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                  if (PARITY != 0) begin
                     state_d = S_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     bit_d   = '0;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               bit_d   = '0;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                  // Chaining into the next start bit here is what removes the idle gap.
                  if (!empty) begin
                     pop     = 1'b1;
                     state_d = S_START;
                     tx_d    = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      if (pop) begin
         shift_d = head;
         par_d   = head_par;
         bit_d   = '0;
         baud_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations (8N1, 8E1, 8O1, 7O2) at 10 clocks per bit,
// line waveforms compared cycle by cycle against frames built from the framing rules.
module tb_uart_tx_param;

   localparam int CF  = 1000000;
   localparam int BR  = 100000;
   localparam int CPB = CF / BR;
   localparam int NI  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       valid_r [NI];
   logic [7:0] data_r  [NI];
   logic       ready_w [NI];
   logic       tx_w    [NI];
   logic       busy_w  [NI];
   logic [2:0] cnt_w   [NI];

   int db_c  [NI] = '{8, 8, 8, 7};
   int par_c [NI] = '{0, 2, 1, 1};
   int sb_c  [NI] = '{1, 1, 1, 2};

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   bit   exp_q    [$];
   logic obs_tx   [$];
   logic obs_busy [$];
   int   acc_cyc  [$];
   int   acc_cnt  [$];
   logic acc_rdy  [$];

   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
      .clk(clk), .rst_n(rst_n), .tx_valid(valid_r[0]), .tx_ready(ready_w[0]),
      .tx_data(data_r[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .fifo_count(cnt_w[0]));

   uart_tx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
      .clk(clk), .rst_n(rst_n), .tx_valid(valid_r[1]), .tx_ready(ready_w[1]),
      .tx_data(data_r[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .fifo_count(cnt_w[1]));

   uart_tx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
      .clk(clk), .rst_n(rst_n), .tx_valid(valid_r[2]), .tx_ready(ready_w[2]),
      .tx_data(data_r[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .fifo_count(cnt_w[2]));

   uart_tx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .PARITY(1),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u_7o2 (
      .clk(clk), .rst_n(rst_n), .tx_valid(valid_r[3]), .tx_ready(ready_w[3]),
      .tx_data(data_r[3][6:0]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .fifo_count(cnt_w[3]));

   // Reference frame: start 0, data LSB first, optional parity, stop bits; each bit held CPB cycles.
   function automatic void add_frame(int k, logic [7:0] w);
      bit bits [$];
      int ones = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < db_c[k]; i++) begin
         bits.push_back(w[i]);
         ones += int'(w[i]);
      end
      if (par_c[k] == 1) bits.push_back((ones % 2) == 0);
      else if (par_c[k] == 2) bits.push_back((ones % 2) == 1);
      for (int i = 0; i < sb_c[k]; i++) bits.push_back(1'b1);
      foreach (bits[i]) for (int c = 0; c < CPB; c++) exp_q.push_back(bits[i]);
   endfunction

   task automatic push_words(int k, logic [7:0] ws [$]);
      acc_cyc.delete(); acc_cnt.delete(); acc_rdy.delete();
      foreach (ws[i]) begin
         int guard = 0;
         data_r[k]  = ws[i];
         valid_r[k] = 1'b1;
         while (ready_w[k] !== 1'b1 && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
         end
         if (guard >= 2000) begin
            n_tests++; n_fail++;
            $display("FAIL push_timeout inst=%0d word=%0d: ready=%b, required 1", k, i, ready_w[k]);
            break;
         end
         @(posedge clk); #1;
         acc_cyc.push_back(cyc);
         acc_cnt.push_back(int'(cnt_w[k]));
         acc_rdy.push_back(ready_w[k]);
      end
      valid_r[k] = 1'b0;
   endtask

   // Records tx/busy for n cycles, starting with the edge after the first accept.
   task automatic capture(int k, int n);
      obs_tx.delete(); obs_busy.delete();
      @(posedge clk); #1;
      repeat (n) begin
         @(posedge clk); #1;
         obs_tx.push_back(tx_w[k]);
         obs_busy.push_back(busy_w[k]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int k = 0; k < NI; k++) begin valid_r[k] = 1'b0; data_r[k] = 8'h00; end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         n_tests++;
         if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || ready_w[k] !== 1'b1 || cnt_w[k] !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_values inst=%0d: tx=%b busy=%b ready=%b count=%0d, required 1 0 1 0",
                     k, tx_w[k], busy_w[k], ready_w[k], cnt_w[k]);
         end
      end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_start_latency();
      logic [7:0] ws [$];
      ws.push_back(8'($urandom));
      push_words(0, ws);
      n_tests++;
      if (cnt_w[0] !== 3'd1 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_accept_edge: count=%0d tx=%b busy=%b, required 1 1 0", cnt_w[0], tx_w[0], busy_w[0]);
      end
      @(posedge clk); #1;
      n_tests++;
      if (cnt_w[0] !== 3'd0 || tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL latency_pop_edge: count=%0d tx=%b busy=%b, required 0 0 1", cnt_w[0], tx_w[0], busy_w[0]);
      end
      repeat (12 * CPB) @(posedge clk);
      #1;
   endtask

   // Single-word frames on instance k: one fixed word then a random one.
   task automatic test_frames(int k, logic [7:0] fixed, string name);
      for (int r = 0; r < 2; r++) begin
         logic [7:0] ws [$];
         int errs = 0;
         ws.push_back(r == 0 ? fixed : 8'($urandom));
         exp_q.delete();
         add_frame(k, ws[0]);
         fork
            push_words(k, ws);
            capture(k, exp_q.size() + 1);
         join
         foreach (exp_q[i]) if (obs_tx[i] !== exp_q[i] || obs_busy[i] !== 1'b1) errs++;
         n_tests++;
         if (errs != 0 || obs_tx[$] !== 1'b1 || obs_busy[$] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_frame word=%h: %0d bad cycles, end tx=%b busy=%b, required 0 bad and end 1 0",
                     name, ws[0], errs, obs_tx[$], obs_busy[$]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] ws [$];
      int errs = 0;
      int exp_cnt [6] = '{1, 1, 2, 3, 4, 4};
      exp_q.delete();
      for (int i = 1; i <= 6; i++) begin ws.push_back(8'(i)); add_frame(0, 8'(i)); end
      fork
         push_words(0, ws);
         capture(0, exp_q.size() + 1);
      join
      for (int i = 0; i < 6; i++) begin
         n_tests++;
         if (acc_cnt.size() != 6 || acc_cnt[i] !== exp_cnt[i]) begin
            n_fail++;
            $display("FAIL bp_count accept=%0d: count=%0d, required %0d", i,
                     (acc_cnt.size() > i) ? acc_cnt[i] : -1, exp_cnt[i]);
         end
      end
      n_tests++;
      if (acc_rdy.size() != 6 || acc_rdy[4] !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_ready_drop: ready after 5th accept=%b, required 0", acc_rdy.size() > 4 ? acc_rdy[4] : 1'bx);
      end
      n_tests++;
      if (acc_cyc.size() != 6 || (acc_cyc[5] - acc_cyc[0]) != (10 * CPB + 2)) begin
         n_fail++;
         $display("FAIL bp_sixth_accept: offset=%0d cycles, required %0d",
                  acc_cyc.size() == 6 ? acc_cyc[5] - acc_cyc[0] : -1, 10 * CPB + 2);
      end
      foreach (exp_q[i]) if (obs_tx[i] !== exp_q[i] || obs_busy[i] !== 1'b1) errs++;
      n_tests++;
      if (errs != 0 || obs_tx[$] !== 1'b1 || obs_busy[$] !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_stream: %0d bad cycles, end tx=%b busy=%b, required 0 bad and end 1 0",
                  errs, obs_tx[$], obs_busy[$]);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < NI; k++) begin
         logic [7:0] ws [$];
         int errs = 0;
         exp_q.delete();
         for (int i = 0; i < 3; i++) begin ws.push_back(8'($urandom)); add_frame(k, ws[i]); end
         fork
            push_words(k, ws);
            capture(k, exp_q.size() + 1);
         join
         foreach (exp_q[i]) if (obs_tx[i] !== exp_q[i] || obs_busy[i] !== 1'b1) errs++;
         n_tests++;
         if (errs != 0 || obs_tx[$] !== 1'b1 || obs_busy[$] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stream inst=%0d: %0d bad cycles, end tx=%b busy=%b, required 0 bad and end 1 0",
                     k, errs, obs_tx[$], obs_busy[$]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] ws [$];
      logic [7:0] nw [$];
      int errs = 0;
      ws.push_back(8'h11); ws.push_back(8'h22); ws.push_back(8'h33);
      exp_q.delete();
      add_frame(0, 8'h11);
      push_words(0, ws);
      // First frame started one edge after the first accept; land mid data bit 3.
      repeat (45 - (cyc - acc_cyc[0])) @(posedge clk);
      #1;
      n_tests++;
      if (tx_w[0] !== exp_q[44] || busy_w[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_line: tx=%b busy=%b, required %b 1", tx_w[0], busy_w[0], exp_q[44]);
      end
      #3 rst_n = 1'b0;
      #1;
      n_tests++;
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || cnt_w[0] !== 3'd0 || ready_w[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset: tx=%b busy=%b count=%0d ready=%b, required 1 0 0 1",
                  tx_w[0], busy_w[0], cnt_w[0], ready_w[0]);
      end
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (30) begin
         @(posedge clk); #1;
         if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || cnt_w[0] !== 3'd0) errs++;
      end
      n_tests++;
      if (errs != 0) begin
         n_fail++;
         $display("FAIL post_reset_idle: %0d non-idle cycles, required 0", errs);
      end
      errs = 0;
      nw.push_back(8'h7E);
      exp_q.delete();
      add_frame(0, 8'h7E);
      fork
         push_words(0, nw);
         capture(0, exp_q.size() + 1);
      join
      foreach (exp_q[i]) if (obs_tx[i] !== exp_q[i] || obs_busy[i] !== 1'b1) errs++;
      n_tests++;
      if (errs != 0 || obs_tx[$] !== 1'b1 || obs_busy[$] !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_frame: %0d bad cycles, end tx=%b busy=%b, required 0 bad and end 1 0",
                  errs, obs_tx[$], obs_busy[$]);
      end
   endtask

   task automatic test_ignore_data();
      logic [7:0] ws [$];
      int errs = 0;
      int cnt_errs = 0;
      ws.push_back(8'($urandom));
      exp_q.delete();
      add_frame(0, ws[0]);
      fork
         push_words(0, ws);
         capture(0, exp_q.size() + 1);
         begin
            @(posedge clk); @(posedge clk); #2;
            repeat (80) begin
               data_r[0] = 8'($urandom);
               @(posedge clk); #2;
               if (cnt_w[0] !== 3'd0) cnt_errs++;
            end
         end
      join
      foreach (exp_q[i]) if (obs_tx[i] !== exp_q[i] || obs_busy[i] !== 1'b1) errs++;
      n_tests++;
      if (errs != 0 || cnt_errs != 0) begin
         n_fail++;
         $display("FAIL ignore_data: %0d bad line cycles, %0d cycles with count!=0, required 0 and 0", errs, cnt_errs);
      end
   endtask

   initial begin
      test_reset();
      test_start_latency();
      test_frames(0, 8'hA5, "8n1");
      test_frames(1, 8'h3C, "8e1");
      test_frames(2, 8'h3C, "8o1");
      test_frames(3, 8'h55, "7o2");
      test_backpressure();
      test_back_to_back();
      test_reset_mid_frame();
      test_ignore_data();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1);
   end

endmodule
